// File: rtl/btn_sched_pkg.sv
// Shared defaults and the output FSM state type for the button event scheduler.
package btn_sched_pkg;

    localparam int N_BTN_DEF       = 4;
    localparam int DB_LEN_DEF      = 4;
    localparam int HOLD_CYCLES_DEF = 100_000_000;

    // Output FSM states
    // state     | meaning
    // S_IDLE    | no event presented; arbiter may grant a pending request
    // S_PRESENT | ev_valid high; ev_id/ev_long frozen until accepted
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/btn_channel.sv
// One pushbutton lane: debounce shift register, press edge detect and hold counter.
module btn_channel
    import btn_sched_pkg::*;
#(
    parameter int DB_LEN      = DB_LEN_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_i,
    output logic press_edge_o,
    output logic long_hit_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD_CYCLES - 1);

    logic [DB_LEN-1:0] shift_q, shift_d;
    logic [DB_LEN:0]   shift_ext;
    logic              deb;
    logic              deb_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Shift the raw level in; debounced only when the whole window is high.
    always_comb begin
        shift_ext = {shift_q, pb_i};
        shift_d   = shift_ext[DB_LEN-1:0];
        deb       = &shift_q;
        cnt_d     = cnt_q;
        if (!deb) begin
            cnt_d = '0;
        end else if (cnt_q != HOLD_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        press_edge_o = deb & ~deb_q;
        // Counter saturates at HOLD_MAX, so this fires once per continuous hold.
        long_hit_o   = deb && (cnt_q == HOLD_M1);
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            deb_q   <= deb;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_scheduler.sv
// Debounced button events (short and long press) arbitrated round-robin onto a
// single valid/ready event port, with sticky per-button lost-event flags.
module btn_event_scheduler
    import btn_sched_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEF,
    parameter int DB_LEN      = DB_LEN_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    localparam int IW         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IW-1:0]    ev_id,
    output logic             ev_long,
    output logic [N_BTN-1:0] ovf,
    input  logic             ovf_clr
);

    logic [N_BTN-1:0] press_edge, long_hit;
    logic [N_BTN-1:0] spend_q, spend_d, lpend_q, lpend_d, ovf_q, ovf_d;
    logic [N_BTN-1:0] spend_clr, lpend_clr, spend_keep, lpend_keep, req;
    logic [IW-1:0]    rr_q, rr_d, id_q, id_d, grant_idx;
    logic             long_q, long_d, grant_found;
    state_e           state_q, state_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .DB_LEN      (DB_LEN),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .pb_i         (pb[g]),
            .press_edge_o (press_edge[g]),
            .long_hit_o   (long_hit[g])
        );
    end

    // Round-robin pick: first requester at or after rr_q, scanning with wrap.
    always_comb begin
        int idx;
        idx         = 0;
        req         = spend_q | lpend_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % N_BTN;
            if (req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    // Output FSM next state, event latch and grant-side clears.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        long_d    = long_q;
        rr_d      = rr_q;
        spend_clr = '0;
        lpend_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    id_d    = grant_idx;
                    // Short event of a button goes out before its long event.
                    long_d  = ~spend_q[grant_idx];
                    if (spend_q[grant_idx]) spend_clr[grant_idx] = 1'b1;
                    else                    lpend_clr[grant_idx] = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ev_ready) begin
                    state_d = S_IDLE;
                    rr_d    = (id_q == IW'(N_BTN - 1)) ? '0 : id_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending bits hold one event each; an edge landing on a held bit is lost.
    always_comb begin
        spend_keep = spend_q & ~spend_clr;
        lpend_keep = lpend_q & ~lpend_clr;
        spend_d    = spend_keep | press_edge;
        lpend_d    = lpend_keep | long_hit;
        ovf_d      = ovf_clr ? '0
                   : (ovf_q | (press_edge & spend_keep) | (long_hit & lpend_keep));
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            spend_q <= '0;
            lpend_q <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            spend_q <= spend_d;
            lpend_q <= lpend_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            long_q  <= long_d;
        end
    end

    assign ev_valid = (state_q == S_PRESENT);
    assign ev_id    = id_q;
    assign ev_long  = long_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with N_BTN=4, DB_LEN=4, HOLD_CYCLES=20.
module tb_btn_event_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb = '0;
    logic       ev_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_long;
    logic [3:0] ovf;

    int checks = 0;
    int errors = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    btn_event_scheduler #(
        .N_BTN       (4),
        .DB_LEN      (4),
        .HOLD_CYCLES (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pb       (pb),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .ev_long  (ev_long),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    // Log each accepted event as id*2+long; inputs only move just after posedge.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) acc_q.push_back(int'(ev_id) * 2 + int'(ev_long));
    end

    function automatic int acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pb  = '0;
        repeat (2) tick();
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_id",    32'(ev_id),    0);
        check("rst_long",  32'(ev_long),  0);
        check("rst_ovf",   32'(ovf),      0);
        acc_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [3:0] mask, input int hi);
        pb = mask;
        repeat (hi) tick();
        pb = '0;
        repeat (10) tick();
    endtask

    initial begin
        logic [5:0] bounce;
        bounce = 6'b011011;

        // Single short press, latency DB_LEN+2
        do_reset();
        ev_ready = 1'b1;
        pb = 4'b0100;
        repeat (5) tick();
        check("lat_before", 32'(ev_valid), 0);
        tick();
        check("lat_valid", 32'(ev_valid), 1);
        check("lat_id",    32'(ev_id),    2);
        check("lat_long",  32'(ev_long),  0);
        repeat (4) tick();
        pb = '0;
        repeat (30) tick();
        check("single_cnt", 32'(acc_q.size()), 1);
        check("single_ev0", 32'(acc_at(0)), 4);

        // Bounce never fills the window
        for (int i = 0; i < 6; i++) begin
            pb = {3'b000, bounce[i]};
            tick();
        end
        pb = '0;
        repeat (20) tick();
        check("bounce_cnt", 32'(acc_q.size()), 1);

        // Contention from rr_ptr=0
        do_reset();
        ev_ready = 1'b1;
        pulse(4'b1010, 8);
        check("cont_cnt", 32'(acc_q.size()), 2);
        check("cont_ev0", 32'(acc_at(0)), 2);
        check("cont_ev1", 32'(acc_at(1)), 6);

        // Button 1 presented and stalled; re-press 1 then press 0 while stalled
        ev_ready = 1'b0;
        pulse(4'b0010, 8);
        check("wrap_valid", 32'(ev_valid), 1);
        check("wrap_id",    32'(ev_id),    1);
        pulse(4'b0010, 8);
        pulse(4'b0001, 8);
        check("wrap_ovf",   32'(ovf),   0);
        check("wrap_hold",  32'(ev_id), 1);
        ev_ready = 1'b1;
        repeat (20) tick();
        check("wrap_cnt", 32'(acc_q.size()), 5);
        check("wrap_ev2", 32'(acc_at(2)), 2);
        check("wrap_ev3", 32'(acc_at(3)), 0);
        check("wrap_ev4", 32'(acc_at(4)), 2);

        // Backpressure: first press presented, second pending, third is lost
        do_reset();
        ev_ready = 1'b0;
        pulse(4'b0001, 8);
        check("bp_valid1", 32'(ev_valid), 1);
        check("bp_id1",    32'(ev_id),    0);
        pulse(4'b0001, 8);
        check("bp_ovf_none", 32'(ovf), 0);
        pulse(4'b0001, 8);
        check("bp_ovf_set", 32'(ovf),      4'b0001);
        check("bp_valid3",  32'(ev_valid), 1);
        check("bp_id3",     32'(ev_id),    0);
        check("bp_long3",   32'(ev_long),  0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("bp_ovf_clr", 32'(ovf),      0);
        check("bp_still",   32'(ev_valid), 1);
        ev_ready = 1'b1;
        repeat (10) tick();
        check("bp_cnt", 32'(acc_q.size()), 2);
        check("bp_ev0", 32'(acc_at(0)), 0);
        check("bp_ev1", 32'(acc_at(1)), 0);

        // Long press: short at +6, long granted at +25
        do_reset();
        ev_ready = 1'b1;
        pb = 4'b0010;
        repeat (6) tick();
        check("lp_short_valid", 32'(ev_valid), 1);
        check("lp_short_long",  32'(ev_long),  0);
        repeat (18) tick();
        check("lp_not_yet", 32'(ev_valid), 0);
        tick();
        check("lp_valid", 32'(ev_valid), 1);
        check("lp_id",    32'(ev_id),    1);
        check("lp_long",  32'(ev_long),  1);
        repeat (15) tick();
        pb = '0;
        repeat (30) tick();
        check("lp_cnt", 32'(acc_q.size()), 2);
        check("lp_ev0", 32'(acc_at(0)), 2);
        check("lp_ev1", 32'(acc_at(1)), 3);

        // Reset while presenting discards the event
        do_reset();
        ev_ready = 1'b0;
        pb = 4'b0100;
        repeat (6) tick();
        check("mid_valid", 32'(ev_valid), 1);
        rst = 1'b1;
        pb  = '0;
        #1;
        check("mid_rst_valid", 32'(ev_valid), 0);
        check("mid_rst_id",    32'(ev_id),    0);
        check("mid_rst_long",  32'(ev_long),  0);
        repeat (2) tick();
        rst = 1'b0;
        ev_ready = 1'b1;
        repeat (20) tick();
        check("mid_none", 32'(acc_q.size()), 0);
        pb = 4'b1000;
        repeat (10) tick();
        pb = '0;
        repeat (10) tick();
        check("mid_new_cnt", 32'(acc_q.size()), 1);
        check("mid_new_ev",  32'(acc_at(0)), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
